// File: rtl/crt_scan_engine.sv
`default_nettype none
// ============================================================================
// crt_scan_engine : noop/addx instruction stream to sprite-compare pixel stream
//                   with probe-cycle signal-strength accumulation
// Revision        : 1.0
// ============================================================================
module crt_scan_engine #(
  parameter int XW          = 16,
  parameter int COLS        = 40,
  parameter int ROWS        = 6,
  parameter int SPRITE_HALF = 1,
  parameter int PROBE_FIRST = 20,
  parameter int PROBE_STEP  = 40,
  parameter int SUM_W       = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic                    i_instr_valid,
  output logic                    o_instr_ready,
  input  logic                    i_instr_op,
  input  logic signed [XW-1:0]    i_instr_imm,
  input  logic                    i_instr_end,
  output logic                    o_pix_valid,
  input  logic                    i_pix_ready,
  output logic                    o_pix_lit,
  output logic [$clog2(COLS)-1:0] o_pix_col,
  output logic [$clog2(ROWS)-1:0] o_pix_row,
  output logic                    o_pix_last,
  output logic signed [XW-1:0]    o_x_out,
  output logic signed [SUM_W-1:0] o_sum,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int c_CLW   = $clog2(COLS);
  localparam int c_RLW   = $clog2(ROWS);
  localparam int c_FRAME = COLS * ROWS;
  localparam int c_CW    = $clog2(c_FRAME + 2);
  localparam int c_PMAX  = (PROBE_FIRST > PROBE_STEP) ? PROBE_FIRST : PROBE_STEP;
  localparam int c_PW    = $clog2(c_PMAX + 1);
  localparam int c_PRW   = c_CW + 1 + XW;
  localparam logic signed [XW+1:0] c_SH = (XW+2)'(SPRITE_HALF);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EMIT1 = 3'd2,
    S_EMIT2 = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  r_state, w_state_nx;
  logic signed [XW-1:0]    r_x, r_imm;
  logic                    r_op, r_lit;
  logic [c_CW-1:0]         r_c;
  logic [c_CLW-1:0]        r_col, w_col_nx;
  logic [c_RLW-1:0]        r_row, w_row_nx;
  logic [c_PW-1:0]         r_pcnt;
  logic signed [SUM_W-1:0] r_sum;
  logic signed [c_PRW-1:0] w_prod;
  logic                    w_emit, w_acc, w_last, w_take, w_probe;

  // Column minus X at two extra bits so negative or far-off X never aliases into the sprite.
  function automatic logic f_lit(input logic [c_CLW-1:0] col, input logic signed [XW-1:0] x);
    logic signed [XW+1:0] d;
    d = $signed({{(XW+2-c_CLW){1'b0}}, col}) - (XW+2)'(x);
    return (d <= c_SH) && (d >= -c_SH);
  endfunction

  assign w_emit  = (r_state == S_EMIT1) || (r_state == S_EMIT2);
  assign w_acc   = w_emit && i_pix_ready;
  assign w_last  = (r_c == c_CW'(c_FRAME));
  assign w_take  = i_instr_valid || i_instr_end;
  assign w_probe = (r_pcnt == '0);
  assign w_prod  = c_PRW'($signed({1'b0, r_c})) * c_PRW'(r_x);

  always_comb begin
    w_col_nx = r_col + 1'b1;
    w_row_nx = r_row;
    if (r_col == c_CLW'(COLS - 1)) begin
      w_col_nx = '0;
      w_row_nx = (r_row == c_RLW'(ROWS - 1)) ? '0 : r_row + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (i_start) w_state_nx = S_FETCH;
      S_FETCH:        if (w_take)  w_state_nx = S_EMIT1;
      S_EMIT1: if (w_acc) w_state_nx = w_last ? S_DONE : (r_op ? S_EMIT2 : S_FETCH);
      S_EMIT2: if (w_acc) w_state_nx = w_last ? S_DONE : S_FETCH;
      default:            w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x    <= XW'(1);
      r_imm  <= '0;
      r_op   <= 1'b0;
      r_lit  <= 1'b0;
      r_c    <= c_CW'(1);
      r_col  <= '0;
      r_row  <= '0;
      r_pcnt <= c_PW'(PROBE_FIRST - 1);
      r_sum  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_x    <= XW'(1);
            r_c    <= c_CW'(1);
            r_col  <= '0;
            r_row  <= '0;
            r_pcnt <= c_PW'(PROBE_FIRST - 1);
            r_sum  <= '0;
          end
        end
        S_FETCH: begin
          // An exhausted program with nothing offered runs as noop without a handshake.
          if (w_take) begin
            r_op  <= i_instr_valid & i_instr_op;
            r_imm <= i_instr_valid ? i_instr_imm : '0;
            r_lit <= f_lit(r_col, r_x);
          end
        end
        S_EMIT1, S_EMIT2: begin
          if (w_acc) begin
            r_c    <= r_c + 1'b1;
            r_col  <= w_col_nx;
            r_row  <= w_row_nx;
            r_pcnt <= w_probe ? c_PW'(PROBE_STEP - 1) : r_pcnt - 1'b1;
            if (w_probe) r_sum <= r_sum + SUM_W'(w_prod);
            if (r_state == S_EMIT1) r_lit <= f_lit(w_col_nx, r_x);
            else                    r_x   <= r_x + r_imm;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_instr_ready = (r_state == S_FETCH);
  assign o_pix_valid   = w_emit;
  assign o_pix_lit     = r_lit;
  assign o_pix_col     = r_col;
  assign o_pix_row     = r_row;
  assign o_pix_last    = w_emit && w_last;
  assign o_x_out       = r_x;
  assign o_sum         = r_sum;
  assign o_busy        = (r_state == S_FETCH) || w_emit;
  assign o_done        = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_crt_scan_engine.sv
`default_nettype none
// ============================================================================
// tb_crt_scan_engine : directed and randomized bench with a frame-level model
// Revision           : 1.0
// ============================================================================
module tb_crt_scan_engine;

  localparam int XW    = 16;
  localparam int COLS  = 40;
  localparam int ROWS  = 6;
  localparam int FRAME = COLS * ROWS;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 i_start = 1'b0, i_instr_valid = 1'b0, i_instr_op = 1'b0;
  logic                 i_instr_end = 1'b0, i_pix_ready = 1'b0;
  logic signed [XW-1:0] i_instr_imm = '0;
  logic                 o_instr_ready, o_pix_valid, o_pix_lit, o_pix_last, o_busy, o_done;
  logic [5:0]           o_pix_col;
  logic [2:0]           o_pix_row;
  logic signed [XW-1:0] o_x_out;
  logic signed [31:0]   o_sum;

  crt_scan_engine #(
    .XW(XW), .COLS(COLS), .ROWS(ROWS), .SPRITE_HALF(1),
    .PROBE_FIRST(20), .PROBE_STEP(40), .SUM_W(32)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_instr_valid(i_instr_valid), .o_instr_ready(o_instr_ready),
    .i_instr_op(i_instr_op), .i_instr_imm(i_instr_imm), .i_instr_end(i_instr_end),
    .o_pix_valid(o_pix_valid), .i_pix_ready(i_pix_ready), .o_pix_lit(o_pix_lit),
    .o_pix_col(o_pix_col), .o_pix_row(o_pix_row), .o_pix_last(o_pix_last),
    .o_x_out(o_x_out), .o_sum(o_sum), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int p_op[$];
  int p_imm[$];
  int exp_x[FRAME+1];
  bit exp_sec[FRAME+1];
  int exp_sum_at[FRAME+1];
  int exp_sum, exp_xf, exp_cons;
  int got_x[FRAME+1];
  bit got_lit[FRAME+1];
  int n_last;
  bit ab;

  int sx[6] = '{1, 1, 1, 4, 4, -1};
  bit sl[6] = '{1, 1, 1, 1, 1, 0};

  // 0 encodes noop (the example contains no addx 0)
  int EX[146] = '{
    15,-11,6,-3,5,-1,-8,13,4,0,   -1,5,-1,5,-1,5,-1,5,-1,-35,
    1,24,-19,1,16,-11,0,0,21,-15, 0,0,-3,9,1,-3,8,1,5,0,
    0,0,0,0,-36,0,1,7,0,0,        0,2,6,0,0,0,0,0,1,0,
    0,7,1,0,-13,13,7,0,1,-33,     0,0,0,2,0,0,0,8,0,-1,
    2,1,0,17,-9,1,1,-3,11,0,      0,1,0,1,0,0,-13,-19,1,3,
    26,-30,12,-1,3,1,0,0,0,-9,    18,1,2,0,0,9,0,0,0,-1,
    2,-37,1,3,0,15,-21,22,-6,1,   0,2,1,0,-10,0,0,20,1,2,
    2,-6,-11,0,0,0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_instr_ready"}, o_instr_ready, 0);
    chk({tag, "_pix_valid"},   o_pix_valid,   0);
    chk({tag, "_pix_lit"},     o_pix_lit,     0);
    chk({tag, "_pix_col"},     o_pix_col,     0);
    chk({tag, "_pix_row"},     o_pix_row,     0);
    chk({tag, "_pix_last"},    o_pix_last,    0);
    chk({tag, "_x_out"},       o_x_out,       1);
    chk({tag, "_sum"},         o_sum,         0);
    chk({tag, "_busy"},        o_busy,        0);
    chk({tag, "_done"},        o_done,        0);
  endtask

  task automatic load_example();
    p_op.delete();
    p_imm.delete();
    for (int i = 0; i < 146; i++) begin
      p_op.push_back((EX[i] != 0) ? 1 : 0);
      p_imm.push_back(EX[i]);
    end
  endtask

  // Cycle-by-cycle X timeline from the instruction list, then probe sums over it.
  task automatic build_model();
    int x = 1, c = 1, i = 0, run = 0, op, imm;
    exp_cons = 0;
    while (c <= FRAME) begin
      op = 0;
      imm = 0;
      if (i < p_op.size()) begin
        op = p_op[i];
        imm = p_imm[i];
        i++;
        exp_cons++;
      end
      exp_x[c] = x;
      exp_sec[c] = 1'b0;
      c++;
      if (op == 1 && c <= FRAME) begin
        exp_x[c] = x;
        exp_sec[c] = 1'b1;
        c++;
        x = int'(shortint'(x + imm));
      end
    end
    exp_xf = x;
    for (int k = 1; k <= FRAME; k++) begin
      exp_sum_at[k] = run;
      if (k >= 20 && (k - 20) % 40 == 0) run += k * exp_x[k];
    end
    exp_sum = run;
  endtask

  task automatic do_start();
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic run_frame(input int stall_pct, input int abort_pc, output bit aborted);
    int ip = 0, pc = 0, cyc = 0, d;
    bit stall_prev = 1'b0;
    logic [63:0] snap = '0, cur;
    aborted = 1'b0;
    n_last = 0;
    forever begin
      i_start = (stall_pct > 0) ? 1'($urandom_range(1)) : 1'b0;
      if (ip < p_op.size()) begin
        i_instr_end   = 1'b0;
        i_instr_valid = ($urandom_range(99) >= stall_pct);
        i_instr_op    = 1'(p_op[ip]);
        i_instr_imm   = XW'(p_imm[ip]);
      end else begin
        i_instr_valid = 1'b0;
        i_instr_op    = 1'b0;
        i_instr_imm   = '0;
        i_instr_end   = 1'b1;
      end
      i_pix_ready = ($urandom_range(99) >= stall_pct);
      @(negedge clk);
      cur = {5'd0, o_pix_lit, o_pix_col, o_pix_row, o_pix_last, o_x_out, o_sum};
      if (stall_prev) chk("stall_hold", cur, snap);
      stall_prev = o_pix_valid && !i_pix_ready;
      snap = cur;
      if (o_done || cyc >= 6000) break;
      if (abort_pc > 0 && o_pix_valid && pc >= abort_pc && pc < FRAME && exp_sec[pc+1]) begin
        aborted = 1'b1;
        break;
      end
      if (o_pix_valid && i_pix_ready && pc < FRAME) begin
        pc++;
        d = ((pc - 1) % COLS) - exp_x[pc];
        chk("pix_col",  o_pix_col,  (pc - 1) % COLS);
        chk("pix_row",  o_pix_row,  (pc - 1) / COLS);
        chk("pix_lit",  o_pix_lit,  (d >= -1 && d <= 1));
        chk("pix_last", o_pix_last, (pc == FRAME));
        chk("pix_x",    o_x_out,    exp_x[pc]);
        chk("pix_sum",  o_sum,      exp_sum_at[pc]);
        got_x[pc]   = o_x_out;
        got_lit[pc] = o_pix_lit;
        if (o_pix_last) n_last++;
      end else if (o_pix_valid && i_pix_ready) begin
        pc++;
      end
      if (o_instr_ready && i_instr_valid) ip++;
      @(posedge clk);
      #1;
      cyc++;
    end
    i_start = 1'b0;
    i_pix_ready = 1'b0;
    i_instr_valid = 1'b0;
    i_instr_end = 1'b0;
    chk("frame_timeout", (cyc < 6000), 1);
    if (!aborted) begin
      chk("pix_count",      pc,      FRAME);
      chk("instr_consumed", ip,      exp_cons);
      chk("sum_final",      o_sum,   exp_sum);
      chk("x_final",        o_x_out, exp_xf);
      chk("done_flag",      o_done,  1);
      chk("busy_flag",      o_busy,  0);
      chk("last_count",     n_last,  1);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset("rst");

    // Short program followed by instr_end
    p_op  = '{0, 1, 1};
    p_imm = '{0, 3, -5};
    build_model();
    do_start();
    run_frame(0, 0, ab);
    for (int k = 0; k < 6; k++) begin
      chk("short_x",   got_x[k+1],   sx[k]);
      chk("short_lit", got_lit[k+1], sl[k]);
    end

    // Example program, free-flowing
    load_example();
    build_model();
    do_start();
    run_frame(0, 0, ab);
    chk("ex_sum_13140", o_sum, 13140);
    for (int col = 0; col < COLS; col++) chk("ex_row0", got_lit[col+1], ((col % 4) < 2));

    // Example program with random stalls on both streams and stray start pulses
    do_start();
    run_frame(30, 0, ab);
    chk("stall_sum_13140", o_sum, 13140);

    // addx whose first cycle is the final pixel
    p_op.delete();
    p_imm.delete();
    for (int i = 0; i < 239; i++) begin p_op.push_back(0); p_imm.push_back(0); end
    for (int i = 0; i < 5; i++)   begin p_op.push_back(1); p_imm.push_back(5); end
    build_model();
    do_start();
    run_frame(0, 0, ab);
    chk("span_x240", got_x[FRAME], 1);
    i_instr_valid = 1'b1;
    i_instr_op    = 1'b1;
    i_instr_imm   = 16'sd5;
    repeat (4) begin
      @(negedge clk);
      chk("span_ready", o_instr_ready, 0);
      chk("span_x",     o_x_out,       1);
      chk("span_done",  o_done,        1);
    end
    i_instr_valid = 1'b0;

    // Sprite edges and X wrap
    p_op.delete();
    p_imm.delete();
    p_op.push_back(1); p_imm.push_back(-2);
    for (int i = 0; i < 38; i++) begin p_op.push_back(0); p_imm.push_back(0); end
    p_op.push_back(1); p_imm.push_back(-1);
    for (int i = 0; i < 38; i++) begin p_op.push_back(0); p_imm.push_back(0); end
    p_op.push_back(1); p_imm.push_back(42);
    for (int i = 0; i < 37; i++) begin p_op.push_back(0); p_imm.push_back(0); end
    p_op.push_back(1); p_imm.push_back(-39);
    p_op.push_back(1); p_imm.push_back(32767);
    build_model();
    do_start();
    run_frame(0, 0, ab);
    chk("edge_xm1_col0",  got_lit[41],  1);
    chk("edge_xm2_col0",  got_lit[81],  0);
    chk("edge_x40_col39", got_lit[120], 1);
    chk("edge_x40",       got_x[120],   40);
    chk("edge_wrap",      got_x[124],   -32768);

    // Reset while the second half of an addx is on the pixel port
    load_example();
    build_model();
    do_start();
    run_frame(0, 100, ab);
    chk("abort_reached", ab, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset("midrst");
    do_start();
    run_frame(0, 0, ab);
    chk("rerun_sum_13140", o_sum, 13140);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/crt_scan_engine.md
# crt_scan_engine

Parametrised successor to the single-screen CRT pixel block. It fetches a noop/addx instruction stream over a valid/ready handshake, tracks the X register with the correct two-cycle addx timing, and emits one sprite-compare pixel per CPU cycle over a backpressured pixel stream. It also accumulates the probe-cycle signal-strength sum. It sits between the program ROM/reader and the display/UART sink.

## Interface
- XW, 16: width of X register and immediates, signed two's complement
- COLS, 40: pixels per row
- ROWS, 6: rows per frame; frame = COLS*ROWS CPU cycles
- SPRITE_HALF, 1: pixel lit when |col − X| ≤ SPRITE_HALF
- PROBE_FIRST, 20; PROBE_STEP, 40: probe cycles are PROBE_FIRST + k*PROBE_STEP
- SUM_W, 32: signal-strength accumulator width, signed
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a frame; honoured only in IDLE or DONE
- instr_valid  in  1  instruction present
- instr_ready  out  1  engine accepts instruction this cycle
- instr_op  in  1  0 = noop, 1 = addx
- instr_imm  in  XW  addx immediate, signed
- instr_end  in  1  level; program exhausted, remaining cycles execute as noop
- pix_valid  out  1  pixel present
- pix_ready  in  1  sink accepts pixel
- pix_lit  out  1  pixel value
- pix_col  out  $clog2(COLS)  column of pixel
- pix_row  out  $clog2(ROWS)  row of pixel
- pix_last  out  1  final pixel of frame
- x_out  out  XW  current X register
- sum  out  SUM_W  signal-strength sum
- busy  out  1  frame in progress
- done  out  1  frame complete, held until start or rst

## Operation
- States: IDLE, FETCH, EMIT1, EMIT2, DONE.
- IDLE: start=1 → X=1, cycle count c=1, col/row=0, sum=0 → FETCH.
- FETCH: instr_ready=1. If instr_valid, capture op/imm → EMIT1. If !instr_valid && instr_end, capture noop, no handshake → EMIT1. Otherwise stall in FETCH.
- EMIT1: pix_valid=1 for cycle c. On accept: if pix_last → DONE; else if op=addx → EMIT2; else → FETCH.
- EMIT2: pix_valid=1 for cycle c. On accept: X ← X + imm (wrap at XW); pix_last → DONE else → FETCH.
- Every accept: c++; col++, wrapping to 0 with row++ at COLS.
- Pixel uses X value *during* the cycle, i.e. before the addx's update. pix_lit = |col − X| ≤ SPRITE_HALF, evaluated at XW+2 bits signed; negative or out-of-range X is legal.
- Probe: on accept of a cycle c that is a probe cycle, sum ← sum + c*X (signed, truncated to SUM_W).
- The frame ends on the COLS*ROWS-th pixel accept, even mid-addx. The pending addx is discarded, X is not updated, and no further instructions are consumed.
- DONE: done=1, busy=0, instr_ready=0. start → fresh frame, as from IDLE.
- start while busy: ignored.
- busy=1 in FETCH/EMIT1/EMIT2.

## Timing
- Reset values: instr_ready=0, pix_valid=0, pix_lit=0, pix_col=0, pix_row=0, pix_last=0, x_out=1, sum=0, busy=0, done=0; state IDLE.
- rst mid-frame: IDLE on the next edge, all outputs at reset values; the partially fetched instruction is dropped.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- start → FETCH on the next edge. Instruction capture → pix_valid on the next clock.
- Throughput with no stalls: noop = 2 clocks per pixel, addx = 3 clocks per 2 pixels.
- While pix_valid && !pix_ready: pix_lit/col/row/last/x_out/sum are held stable.
- x_out reflects the post-addx value on the clock after the EMIT2 accept.
- The sum update is visible on the clock after the probe pixel accept.
- Frame completion: done=1 on the clock after the pix_last accept.

## Test plan
- Program noop; addx 3; addx −5, then instr_end=1, pix_ready=1 → X during cycles 1..6 = 1,1,1,4,4,−1; pix_lit for cols 0..5 = 1,1,1,1,1,0; x_out=−1 after cycle 5.
- Standard 146-instruction AoC day-10 example, defaults → sum=13140; row 0 pixels = "##..##..##..##..##..##..##..##..##..##.."; 240 pixels; pix_last only on row 5, col 39; done=1.
- Random pix_ready and instr_valid gaps on the example → pixel sequence and sum identical to the no-stall run; outputs stable during each stall; no instruction lost or duplicated.
- addx spanning frame end (addx issued so EMIT1 is pixel 240) → DONE after EMIT1, x_out unchanged, instr_ready stays 0, with instr_valid held high.
- Edge sprite: X=−1 at col 0 → lit; X=40 at col 39 → lit; X=−2 at col 0 → unlit; addx 32767 from X=1 with XW=16 → X wraps to −32768.
- rst asserted mid-EMIT2 → next clock all outputs at reset values, IDLE; subsequent start reproduces the full example, sum=13140.
